// File: rtl/hazard_sb_ctrl_if.sv
// D/E-stage hazard bundle between the pipeline (master) and hazard_sb_ctrl (slave).
// Active-low write enables (WEN_*) are carried unchanged from the datapath.
interface hazard_sb_ctrl_if #(
  parameter int AW = 5,
  parameter int LW = 3
);
  logic          Valid_D;
  logic [AW-1:0] RA0_D, RA1_D;
  logic          RS1Used_D, RS2Used_D;
  logic [AW-1:0] WA_D;
  logic          WEN_D;
  logic [LW-1:0] Lat_D;
  logic [AW-1:0] RA0_E, RA1_E;
  logic          RS1Used_E, RS2Used_E;
  logic [AW-1:0] WA_M1, WA_W;
  logic          WEN_M1, WEN_W;
  logic          Valid_E, Jump, Branch, Taken;
  logic          PCWrite, IMRead, FDWrite, FDFlush, DEFlush;
  logic          Issue;
  logic [1:0]    FW1, FW2;
  logic          Busy;

  modport master (
    output Valid_D, RA0_D, RA1_D, RS1Used_D, RS2Used_D, WA_D, WEN_D, Lat_D,
           RA0_E, RA1_E, RS1Used_E, RS2Used_E, WA_M1, WA_W, WEN_M1, WEN_W,
           Valid_E, Jump, Branch, Taken,
    input  PCWrite, IMRead, FDWrite, FDFlush, DEFlush, Issue, FW1, FW2, Busy
  );

  modport slave (
    input  Valid_D, RA0_D, RA1_D, RS1Used_D, RS2Used_D, WA_D, WEN_D, Lat_D,
           RA0_E, RA1_E, RS1Used_E, RS2Used_E, WA_M1, WA_W, WEN_M1, WEN_W,
           Valid_E, Jump, Branch, Taken,
    output PCWrite, IMRead, FDWrite, FDFlush, DEFlush, Issue, FW1, FW2, Busy
  );
endinterface

// File: rtl/hazard_sb_ctrl.sv
// Latency-tagged scoreboard, redirect/bubble FSM and E-stage bypass select.
// Optional HZ_PERF_EN adds saturating StallCnt/FlushCnt outputs.
module hazard_sb_ctrl #(
  parameter int NREG      = 32,
  parameter int AW        = $clog2(NREG),
  parameter int MAX_LAT   = 4,
  parameter int LW        = $clog2(MAX_LAT+1),
  parameter int FLUSH_CYC = 1
) (
  input  logic CLK,
  input  logic RST,
  hazard_sb_ctrl_if.slave hz
`ifdef HZ_PERF_EN
  ,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
`endif
);
  localparam logic [0:0]    RUN     = 1'b0;
  localparam logic [0:0]    BUBBLE  = 1'b1;
  localparam logic [2:0]    BRELOAD = (FLUSH_CYC > 0) ? 3'(FLUSH_CYC-1) : 3'd0;
  localparam logic [LW-1:0] LMAX    = LW'(MAX_LAT);

  logic [NREG-1:0][LW-1:0] cnt;
  logic [0:0]    state;
  logic [2:0]    bcnt;
  logic [LW-1:0] lat_sat;
  logic          stall, redirect, issue, load, busy;

  assign lat_sat  = (hz.Lat_D > LMAX) ? LMAX : hz.Lat_D;
  assign redirect = hz.Valid_E & (hz.Jump | (hz.Branch & hz.Taken));
  // cnt==1 means the result reaches a bypass by the time the consumer is in E
  assign stall    = hz.Valid_D &
                    ((hz.RS1Used_D & (|hz.RA0_D) & (cnt[hz.RA0_D] > LW'(1))) |
                     (hz.RS2Used_D & (|hz.RA1_D) & (cnt[hz.RA1_D] > LW'(1))));
  assign issue    = ~RST & hz.Valid_D & ~stall & ~redirect & (state == RUN);
  assign load     = issue & ~hz.WEN_D & (|hz.WA_D) & (|hz.Lat_D);

  // entry 0 is only ever written by reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (load && (hz.WA_D == AW'(r)))
          cnt[r] <= lat_sat;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int r = 0; r < NREG; r++) busy = busy | (|cnt[r]);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RUN;
      bcnt  <= '0;
    end else begin
      case (state)
        RUN: if (redirect && (FLUSH_CYC > 0)) begin
          state <= BUBBLE;
          bcnt  <= BRELOAD;
        end
        BUBBLE: begin
          if (redirect)          bcnt  <= BRELOAD;
          else if (bcnt == '0)   state <= RUN;
          else                   bcnt  <= bcnt - 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    hz.PCWrite = 1'b1;
    hz.IMRead  = 1'b1;
    hz.FDWrite = 1'b1;
    hz.FDFlush = 1'b0;
    hz.DEFlush = 1'b0;
    if (redirect) begin
      hz.IMRead  = 1'b0;
      hz.FDFlush = 1'b1;
      hz.DEFlush = 1'b1;
    end else if (state == BUBBLE) begin
      hz.FDFlush = 1'b1;
      hz.DEFlush = 1'b1;
    end else if (stall) begin
      hz.PCWrite = 1'b0;
      hz.IMRead  = 1'b0;
      hz.FDWrite = 1'b0;
      hz.DEFlush = 1'b1;
    end
  end

  function automatic logic [1:0] fw_sel(input logic used, input logic [AW-1:0] ra,
                                        input logic wen_m1, input logic [AW-1:0] wa_m1,
                                        input logic wen_w, input logic [AW-1:0] wa_w);
    if (used && (ra != '0) && !wen_m1 && (ra == wa_m1)) return 2'd1;
    if (used && (ra != '0) && !wen_w  && (ra == wa_w))  return 2'd2;
    return 2'd0;
  endfunction

  assign hz.FW1   = fw_sel(hz.RS1Used_E, hz.RA0_E, hz.WEN_M1, hz.WA_M1, hz.WEN_W, hz.WA_W);
  assign hz.FW2   = fw_sel(hz.RS2Used_E, hz.RA1_E, hz.WEN_M1, hz.WA_M1, hz.WEN_W, hz.WA_W);
  assign hz.Issue = issue;
  assign hz.Busy  = busy;

`ifdef HZ_PERF_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (stall && !redirect && (StallCnt != 32'hFFFF_FFFF)) StallCnt <= StallCnt + 1'b1;
      if (redirect && (FlushCnt != 32'hFFFF_FFFF))           FlushCnt <= FlushCnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_sb_ctrl.sv
// Bench for hazard_sb_ctrl: directed literal scenarios plus randomized traffic
// compared every cycle against a countdown/bubble-count model of the rules.
module tb_hazard_sb_ctrl;
  localparam int NREG = 32, AW = 5, MAX_LAT = 4, LW = 3, FC = 2;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  hazard_sb_ctrl_if #(.AW(AW), .LW(LW)) hz ();
`ifdef HZ_PERF_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  hazard_sb_ctrl #(.NREG(NREG), .AW(AW), .MAX_LAT(MAX_LAT), .LW(LW), .FLUSH_CYC(FC)) dut (
    .CLK(CLK), .RST(RST), .hz(hz)
`ifdef HZ_PERF_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
  );

  int checks = 0, errors = 0;
  int mcnt[NREG];
  int mbub;
  longint mstall, mflush;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) mcnt[r] = 0;
    mbub = 0; mstall = 0; mflush = 0;
  endtask

  function automatic int fw_exp(input logic used, input logic [AW-1:0] ra);
    if (!used || ra == 0) return 0;
    if (!hz.WEN_M1 && ra == hz.WA_M1) return 1;
    if (!hz.WEN_W && ra == hz.WA_W) return 2;
    return 0;
  endfunction

  function automatic bit m_stall();
    return hz.Valid_D && ((hz.RS1Used_D && hz.RA0_D != 0 && mcnt[hz.RA0_D] > 1) ||
                          (hz.RS2Used_D && hz.RA1_D != 0 && mcnt[hz.RA1_D] > 1));
  endfunction

  function automatic bit m_redir();
    return hz.Valid_E && (hz.Jump || (hz.Branch && hz.Taken));
  endfunction

  // expectations straight from the priority table
  task automatic model_check();
    bit st, rd, bb, is, busy;
    int pc, im, fd, ff, df;
    if (RST) model_reset();
    st = m_stall(); rd = m_redir(); bb = (mbub > 0);
    is = !RST && hz.Valid_D && !st && !rd && !bb;
    if (rd)      begin pc = 1; im = 0; fd = 1; ff = 1; df = 1; end
    else if (bb) begin pc = 1; im = 1; fd = 1; ff = 1; df = 1; end
    else if (st) begin pc = 0; im = 0; fd = 0; ff = 0; df = 1; end
    else         begin pc = 1; im = 1; fd = 1; ff = 0; df = 0; end
    busy = 0;
    for (int r = 1; r < NREG; r++) if (mcnt[r] != 0) busy = 1;
    chk("m_PCWrite", hz.PCWrite, pc);
    chk("m_IMRead", hz.IMRead, im);
    chk("m_FDWrite", hz.FDWrite, fd);
    chk("m_FDFlush", hz.FDFlush, ff);
    chk("m_DEFlush", hz.DEFlush, df);
    chk("m_Issue", hz.Issue, is);
    chk("m_FW1", hz.FW1, fw_exp(hz.RS1Used_E, hz.RA0_E));
    chk("m_FW2", hz.FW2, fw_exp(hz.RS2Used_E, hz.RA1_E));
    chk("m_Busy", hz.Busy, busy);
`ifdef HZ_PERF_EN
    chk("m_StallCnt", StallCnt, mstall);
    chk("m_FlushCnt", FlushCnt, mflush);
`endif
  endtask

  task automatic model_next();
    bit st, rd, is;
    int lat;
    if (RST) begin model_reset(); return; end
    st = m_stall(); rd = m_redir();
    is = hz.Valid_D && !st && !rd && (mbub == 0);
    for (int r = 1; r < NREG; r++) if (mcnt[r] > 0) mcnt[r]--;
    if (is && !hz.WEN_D && hz.WA_D != 0 && hz.Lat_D != 0) begin
      lat = int'(hz.Lat_D);
      mcnt[hz.WA_D] = (lat > MAX_LAT) ? MAX_LAT : lat;
    end
    if (rd) begin if (FC > 0) mbub = FC; end
    else if (mbub > 0) mbub--;
    if (st && !rd && mstall < 64'hFFFF_FFFF) mstall++;
    if (rd && mflush < 64'hFFFF_FFFF) mflush++;
  endtask

  task automatic cyc();
    @(negedge CLK);
    model_check();
    model_next();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    hz.Valid_D = 0; hz.RA0_D = 0; hz.RA1_D = 0; hz.RS1Used_D = 0; hz.RS2Used_D = 0;
    hz.WA_D = 0; hz.WEN_D = 1; hz.Lat_D = 0;
    hz.RA0_E = 0; hz.RA1_E = 0; hz.RS1Used_E = 0; hz.RS2Used_E = 0;
    hz.WA_M1 = 0; hz.WA_W = 0; hz.WEN_M1 = 1; hz.WEN_W = 1;
    hz.Valid_E = 0; hz.Jump = 0; hz.Branch = 0; hz.Taken = 0;
  endtask

  task automatic produce(input int wa, input int lat);
    idle(); hz.Valid_D = 1; hz.WA_D = AW'(wa); hz.WEN_D = 0; hz.Lat_D = LW'(lat);
  endtask

  task automatic consume(input int ra);
    idle(); hz.Valid_D = 1; hz.RA0_D = AW'(ra); hz.RS1Used_D = 1;
  endtask

  task automatic do_reset();
    RST = 1; idle(); cyc(); cyc(); RST = 0;
  endtask

  initial begin
    int n;
    model_reset();
    RST = 1; idle();
    #1;
    cyc(); cyc();
    RST = 0; hz.Valid_D = 1; #1;
    chk("rst_PCWrite", hz.PCWrite, 1); chk("rst_IMRead", hz.IMRead, 1);
    chk("rst_FDFlush", hz.FDFlush, 0); chk("rst_DEFlush", hz.DEFlush, 0);
    chk("rst_Issue", hz.Issue, 1);     chk("rst_Busy", hz.Busy, 0);
    chk("rst_FW1", hz.FW1, 0);
    cyc();

    // load-use, latency 2: exactly one stall
    produce(5, 2); #1; chk("lu_prod_issue", hz.Issue, 1); cyc();
    consume(5); #1;
    chk("lu_stall_issue", hz.Issue, 0); chk("lu_stall_pc", hz.PCWrite, 0);
    chk("lu_stall_de", hz.DEFlush, 1);  chk("lu_stall_fd", hz.FDWrite, 0);
    cyc(); #1; chk("lu_release", hz.Issue, 1); cyc();

    // 4-cycle producer: three stalls
    idle(); cyc(); cyc();
    produce(7, 4); cyc();
    idle(); hz.Valid_D = 1; hz.RA1_D = 7; hz.RS2Used_D = 1;
    n = 0;
    for (int i = 0; i < 10; i++) begin #1; if (hz.Issue) break; n++; cyc(); end
    chk("mul_stalls", n, 3); chk("mul_busy", hz.Busy, 1);
    cyc(); #1; chk("mul_busy_clr", hz.Busy, 0);

    // WAW: newest latency wins
    produce(3, 4); cyc(); produce(3, 1); cyc();
    consume(3); #1; chk("waw_nostall", hz.Issue, 1); cyc();

    // taken branch while D is stalled, then FC bubbles
    idle(); cyc();
    produce(8, 4); cyc();
    consume(8); #1; chk("br_stall", hz.Issue, 0); cyc();
    hz.Valid_E = 1; hz.Branch = 1; hz.Taken = 1; #1;
    chk("br_imread", hz.IMRead, 0); chk("br_fdflush", hz.FDFlush, 1);
    chk("br_deflush", hz.DEFlush, 1); chk("br_issue", hz.Issue, 0);
    chk("br_pcwrite", hz.PCWrite, 1);
    cyc(); hz.Valid_E = 0; hz.Branch = 0; hz.Taken = 0; #1;
    chk("bub1_imread", hz.IMRead, 1); chk("bub1_fdflush", hz.FDFlush, 1);
    chk("bub1_issue", hz.Issue, 0);
    cyc(); #1; chk("bub2_fdflush", hz.FDFlush, 1);
    cyc(); #1; chk("run_fdflush", hz.FDFlush, 0); chk("run_issue", hz.Issue, 1);
    cyc();

    // bypass priority
    idle(); hz.RA0_E = 9; hz.RS1Used_E = 1; hz.RA1_E = 9; hz.RS2Used_E = 1;
    hz.WA_M1 = 9; hz.WA_W = 9; hz.WEN_M1 = 0; hz.WEN_W = 0; #1;
    chk("fw1_m1", hz.FW1, 1); chk("fw2_m1", hz.FW2, 1); cyc();
    hz.RA0_E = 0; #1; chk("fw1_r0", hz.FW1, 0); cyc();
    hz.RA0_E = 9; hz.WEN_M1 = 1; #1; chk("fw1_w", hz.FW1, 2); chk("fw2_w", hz.FW2, 2); cyc();

`ifdef HZ_PERF_EN
    do_reset();
    produce(5, 4); cyc();
    consume(5); cyc(); cyc(); cyc();
    idle(); hz.Valid_E = 1; hz.Jump = 1; cyc();
    idle(); #1; chk("perf_stall", StallCnt, 3); chk("perf_flush", FlushCnt, 1);
    cyc(); cyc(); cyc();
    produce(6, 4); cyc(); consume(6); cyc();
    RST = 1; #1;
    chk("perf_rst_stall", StallCnt, 0); chk("perf_rst_flush", FlushCnt, 0);
    chk("perf_rst_busy", hz.Busy, 0);   chk("perf_rst_fdflush", hz.FDFlush, 0);
    cyc(); RST = 0;
`endif

    // randomized traffic over a small register window to provoke hazards
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      RST = ($urandom_range(0, 199) == 0);
      hz.Valid_D   = ($urandom_range(0, 7) != 0);
      hz.RA0_D     = AW'($urandom_range(0, 7));
      hz.RA1_D     = AW'($urandom_range(0, 7));
      hz.RS1Used_D = $urandom_range(0, 1);
      hz.RS2Used_D = $urandom_range(0, 1);
      hz.WA_D      = AW'($urandom_range(0, 7));
      hz.WEN_D     = ($urandom_range(0, 3) == 0);
      hz.Lat_D     = LW'($urandom_range(0, 7));
      hz.RA0_E     = AW'($urandom_range(0, 7));
      hz.RA1_E     = AW'($urandom_range(0, 7));
      hz.RS1Used_E = $urandom_range(0, 1);
      hz.RS2Used_E = $urandom_range(0, 1);
      hz.WA_M1     = AW'($urandom_range(0, 7));
      hz.WA_W      = AW'($urandom_range(0, 7));
      hz.WEN_M1    = $urandom_range(0, 1);
      hz.WEN_W     = $urandom_range(0, 1);
      hz.Valid_E   = ($urandom_range(0, 7) == 0);
      hz.Jump      = $urandom_range(0, 1);
      hz.Branch    = $urandom_range(0, 1);
      hz.Taken     = $urandom_range(0, 1);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_sb_ctrl.md
# hazard_sb_ctrl

Parametrised hazard controller for the RISC_toy pipeline: a per-register countdown scoreboard, a redirect/flush state machine and E-stage bypass selection in one block. Sits beside the decode/execute stages. Replaces fixed load-use compare logic with latency-tagged tracking of in-flight writes, so multi-cycle producers stall only as long as needed. Issues PC/IF/ID write enables, pipeline flushes and forwarding selects.

## Interface
- NREG, 32: architectural registers; register 0 is never tracked
- AW, 5: register address width, $clog2(NREG)
- MAX_LAT, 4: largest producer latency, in cycles until forwardable
- LW, 3: latency field width, $clog2(MAX_LAT+1)
- FLUSH_CYC, 1: extra fetch-bubble cycles after a redirect (0..7)
- CLK  in  1  clock
- RST  in  1  reset; asynchronous, active-high
- Valid_D  in  1  valid instruction in D
- RA0_D, RA1_D  in  AW  D-stage source addresses
- RS1Used_D, RS2Used_D  in  1  source actually read
- WA_D  in  AW  D-stage destination
- WEN_D  in  1  D-stage write enable, active-low
- Lat_D  in  LW  cycles after issue until result forwardable; 0 = untracked
- RA0_E, RA1_E  in  AW; RS1Used_E, RS2Used_E  in  1  E-stage sources
- WA_M1, WA_W  in  AW; WEN_M1, WEN_W  in  1 (active-low)  bypass producers
- Valid_E, Jump, Branch, Taken  in  1  E-stage control-flow resolution
- PCWrite, IMRead, FDWrite, FDFlush, DEFlush  out  1  pipeline controls
- Issue  out  1  D instruction advances to E this cycle
- FW1, FW2  out  2  bypass select: 0 regfile, 1 M1, 2 W
- Busy  out  1  any scoreboard entry nonzero

## Operation
- Scoreboard: cnt[r], LW bits, r=1..NREG-1. Each edge, every nonzero cnt decrements by 1.
- On Issue with WEN_D=0, WA_D!=0, Lat_D!=0: cnt[WA_D] <= min(Lat_D, MAX_LAT). Overrides the decrement for that entry (WAW: newest wins).
- Stall = Valid_D & ((RS1Used_D & RA0_D!=0 & cnt[RA0_D]>1) | (RS2Used_D & RA1_D!=0 & cnt[RA1_D]>1)).
- Redirect = Valid_E & (Jump | (Branch & Taken)).
- Issue = Valid_D & ~Stall & ~Redirect & (state==RUN).
- FSM states: RUN, BUBBLE.
  - RUN: Redirect with FLUSH_CYC>0 -> BUBBLE, bcnt <= FLUSH_CYC-1; else stay.
  - BUBBLE: Redirect reloads bcnt <= FLUSH_CYC-1; else bcnt==0 -> RUN, otherwise bcnt-1.
- Outputs, priority order:
  - Redirect: PCWrite=1, IMRead=0, FDWrite=1, FDFlush=1, DEFlush=1.
  - BUBBLE: PCWrite=1, IMRead=1, FDWrite=1, FDFlush=1, DEFlush=1.
  - Stall: PCWrite=0, IMRead=0, FDWrite=0, FDFlush=0, DEFlush=1.
  - Otherwise: PCWrite=IMRead=FDWrite=1, FDFlush=DEFlush=0.
- Forwarding: FW1=1 if RS1Used_E & WEN_M1=0 & RA0_E==WA_M1 & RA0_E!=0; else 2 if the same holds against WA_W/WEN_W; else 0. FW2 identical on RA1_E/RS2Used_E. M1 beats W.
- Redirect never clears the scoreboard; killed instructions were never issued.

## Timing
- Reset: all cnt=0, state RUN, bcnt=0. Outputs then are PCWrite=IMRead=FDWrite=1, FDFlush=DEFlush=0, Issue=Valid_D, FW1=FW2=0, Busy=0.
- Stall, Issue, flush and FW outputs are combinational from inputs and registered state, same cycle.
- A producer issued at edge t with Lat_D=L releases a dependent consumer in D at cycle t+L-1. That consumer reaches E at t+L with a bypass available.
- Lat_D=1 never stalls.
- RST asserted mid-stall or mid-BUBBLE returns to the reset state immediately; no issue during reset.

## Configuration
- HZ_PERF_EN defined: adds outputs StallCnt[31:0] and FlushCnt[31:0].
  - StallCnt counts cycles with Stall & ~Redirect; FlushCnt counts Redirect cycles.
  - Both saturate at 0xFFFFFFFF and clear on RST.
- HZ_PERF_EN undefined: neither port nor counter exists.

## Test plan
- Load-use: issue WA_D=5, Lat_D=2, WEN_D=0; next cycle D reads RA0_D=5 -> Stall=1 for 1 cycle (PCWrite=0, DEFlush=1), then Issue=1.
- Multiply, Lat_D=4 to r7; dependent in D next cycle -> 3 stall cycles, Busy=1 until cnt[7]=0.
- WAW: r3 Lat 4, then r3 Lat 1 next cycle -> cnt[3]=1, dependent on r3 never stalls.
- FLUSH_CYC=2, Taken branch while D is stalled -> redirect cycle (IMRead=0, FDFlush=DEFlush=1, Issue=0), 2 BUBBLE cycles, then RUN.
- Bypass: RA0_E=9, WA_M1=9, WA_W=9, both WEN=0 -> FW1=1; RA0_E=0 -> FW1=0; WEN_M1=1 -> FW1=2.
- HZ_PERF_EN: 3 stalls plus 1 redirect -> StallCnt=3, FlushCnt=1; assert RST mid-stall -> both read 0 and state RUN.
